// File: rtl/draw_cmd_sequencer.sv
// draw_cmd_sequencer: buffers changed cells from the frame tracker and
// serialises each one into a window command plus CELL_PX*CELL_PX pixel beats.
module draw_cmd_sequencer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CELL_PX = 15,
    parameter int unsigned PXW     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           diff,
    input  logic [3:0]     x,
    input  logic [3:0]     y,
    input  logic [2:0]     obj_code,
    input  logic           sync,
    output logic           win_valid,
    input  logic           win_ready,
    output logic [PXW-1:0] col_start,
    output logic [PXW-1:0] col_end,
    output logic [PXW-1:0] row_start,
    output logic [PXW-1:0] row_end,
    output logic           px_valid,
    input  logic           px_ready,
    output logic [15:0]    px_color,
    output logic           frame_done,
    output logic           overflow,
    output logic           busy
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned NBEATS = CELL_PX * CELL_PX;
    localparam int unsigned CNTW   = $clog2(NBEATS) + 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NBEATS - 1);

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] obj;
    } cell_t;

    typedef enum logic [1:0] {IDLE, WIN, FILL} state_t;

    state_t          state;
    cell_t           mem [DEPTH];
    cell_t           head;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     fill;
    logic [AW:0]     fill_nxt;
    logic [CNTW-1:0] beat;
    logic            sync_pending;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            last_beat;
    logic            idle_next;
    logic            done_fire;

    // RGB565 lookup for the object codes; reserved codes draw black
    function automatic logic [15:0] obj_color(input logic [2:0] code);
        case (code)
            3'd1:    obj_color = 16'h07E0;
            3'd2:    obj_color = 16'h03E0;
            3'd3:    obj_color = 16'hF800;
            3'd4:    obj_color = 16'hFFFF;
            default: obj_color = 16'h0000;
        endcase
    endfunction

    // FIFO status, handshake events and frame-done qualification
    always_comb begin
        fill      = wr_ptr - rd_ptr;
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head      = mem[rd_ptr[AW-1:0]];
        pop       = (state == IDLE) && enable && !empty;
        // a pop in the same cycle frees a slot, so a full FIFO still accepts
        push      = enable && diff && (!full || pop);
        drop      = enable && diff && full && !pop;
        fill_nxt  = fill + (AW+1)'(push) - (AW+1)'(pop);
        last_beat = (state == FILL) && px_ready && (beat == LAST_BEAT);
        idle_next = ((state == IDLE) && !pop) || last_beat;
        done_fire = (sync_pending || sync) && (state == IDLE) && empty && !push;
    end

    // change FIFO storage; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cell_t'({x, y, obj_code});
        end
    end

    // sequencer FSM with FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            beat         <= '0;
            sync_pending <= 1'b0;
            win_valid    <= 1'b0;
            px_valid     <= 1'b0;
            col_start    <= '0;
            col_end      <= '0;
            row_start    <= '0;
            row_end      <= '0;
            px_color     <= '0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop) overflow <= 1'b1;
            busy       <= !idle_next || (fill_nxt != '0);
            frame_done <= done_fire;
            if (done_fire)  sync_pending <= 1'b0;
            else if (sync)  sync_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        col_start <= PXW'(head.x) * PXW'(CELL_PX);
                        col_end   <= PXW'(head.x) * PXW'(CELL_PX) + PXW'(CELL_PX - 1);
                        row_start <= PXW'(head.y) * PXW'(CELL_PX);
                        row_end   <= PXW'(head.y) * PXW'(CELL_PX) + PXW'(CELL_PX - 1);
                        px_color  <= obj_color(head.obj);
                        win_valid <= 1'b1;
                        state     <= WIN;
                    end
                end
                WIN: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        px_valid  <= 1'b1;
                        beat      <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (px_ready) begin
                        if (beat == LAST_BEAT) begin
                            px_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            beat <= beat + CNTW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
